// File: rtl/sop_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// sop_mac_sequencer_if
//
// Purpose:
//   Bundles the coefficient register port, the sample input handshake and the
//   result output handshake of the sop_mac_sequencer block.
//
// Signals (direction as seen from the sequencer, i.e. the slave modport):
//   coef_we     in   coefficient write strobe
//   coef_addr   in   coefficient index, 0..3 selects C0..C3
//   coef_wdata  in   coefficient value, SIZE bits
//   coef_err    out  one-cycle pulse when a write is rejected while busy
//   in_valid    in   data_in carries a sample
//   in_ready    out  sequencer can accept a sample
//   data_in     in   unsigned sample, SIZE bits
//   out_valid   out  sop_out carries a result
//   out_ready   in   downstream accepts the result
//   sop_out     out  unsigned sum of products, 2*SIZE+2 bits
//   busy        out  high while a sample is being processed or held
// ---------------------------------------------------------------------------
interface sop_mac_sequencer_if #(
    parameter int SIZE = 4
);
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic [SIZE-1:0]   coef_wdata;
    logic              coef_err;
    logic              in_valid;
    logic              in_ready;
    logic [SIZE-1:0]   data_in;
    logic              out_valid;
    logic              out_ready;
    logic [2*SIZE+1:0] sop_out;
    logic              busy;

    // Sample source / register writer side
    modport master (
        output coef_we, coef_addr, coef_wdata, in_valid, data_in, out_ready,
        input  coef_err, in_ready, out_valid, sop_out, busy
    );

    // Sequencer side
    modport slave (
        input  coef_we, coef_addr, coef_wdata, in_valid, data_in, out_ready,
        output coef_err, in_ready, out_valid, sop_out, busy
    );
endinterface

// File: rtl/sop_mac_sequencer.sv
// ---------------------------------------------------------------------------
// sop_mac_sequencer
//
// Purpose:
//   Computes sop_out = data*C0 + data*C1 + data*C2 + data*C3 using a single
//   SIZE x SIZE multiplier and one accumulator stepped over four cycles.
//   Holds the C0..C3 coefficient bank, written through a register port that
//   is only open while the sequencer is idle.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    sop_mac_sequencer_if.slave (coefficient port, input and output
//          valid/ready handshakes, busy and coef_err status)
//
// Timing:
//   accept edge -> 4 MAC edges -> DONE (out_valid=1) -> consume edge -> IDLE.
//   With out_ready held high a new sample can be taken every 6 cycles.
// ---------------------------------------------------------------------------
module sop_mac_sequencer #(
    parameter int SIZE = 4,
    parameter int TAPS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sop_mac_sequencer_if.slave    bus
);

    localparam int RW = 2 * SIZE + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [SIZE-1:0] r_coef [TAPS];
    logic [SIZE-1:0] r_data_q;
    logic [RW-1:0]   r_acc;
    logic [1:0]      r_tap_cnt;
    logic [RW-1:0]   r_sop;
    logic            r_coef_err;

    logic [2*SIZE-1:0] w_mult;
    logic [RW-1:0]     w_product;
    logic [RW-1:0]     w_sum;
    logic              w_busy;

    // Status and handshake outputs come straight from the state register so
    // that an asynchronous reset drops out_valid and busy immediately.
    assign w_busy        = (r_state != S_IDLE);
    assign bus.busy      = w_busy;
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sop_out   = r_sop;
    assign bus.coef_err  = r_coef_err;

    // Shared multiplier: operands are widened so the full 2*SIZE-bit product
    // is kept, then zero-extended to the accumulator width. The worst case
    // 4*(2^SIZE-1)^2 always fits in 2*SIZE+2 bits, so no overflow handling.
    assign w_mult    = {{SIZE{1'b0}}, r_data_q} * {{SIZE{1'b0}}, r_coef[r_tap_cnt]};
    assign w_product = {2'b00, w_mult};
    assign w_sum     = r_acc + w_product;

    // Coefficient bank. Writes land only in IDLE; the first tap is read on
    // the edge after the accept, so a write coinciding with an accepted
    // sample is already visible to that sample. A write attempted while
    // busy is dropped and flagged on coef_err for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= bus.coef_we && w_busy;
            if (bus.coef_we && !w_busy) begin
                r_coef[bus.coef_addr] <= bus.coef_wdata;
            end
        end
    end

    // Sequencer FSM and datapath. IDLE latches the sample and clears the
    // accumulator; MAC adds one tap per edge and publishes the final sum on
    // tap 3; DONE holds the result until downstream takes it. Going back to
    // IDLE on the consume edge means a sample can never be taken on that
    // same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_data_q  <= '0;
            r_acc     <= '0;
            r_tap_cnt <= 2'd0;
            r_sop     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_data_q  <= bus.data_in;
                        r_acc     <= '0;
                        r_tap_cnt <= 2'd0;
                        r_state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc     <= w_sum;
                    r_tap_cnt <= r_tap_cnt + 2'd1;
                    if (r_tap_cnt == 2'd3) begin
                        r_sop   <= w_sum;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sop_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sop_mac_sequencer
//
// Purpose:
//   Directed bench for sop_mac_sequencer. Expected results are hand computed
//   as data * (C0 + C1 + C2 + C3).
// ---------------------------------------------------------------------------
module tb_sop_mac_sequencer;

    localparam int SIZE = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sop_mac_sequencer_if #(.SIZE(SIZE)) bus ();

    sop_mac_sequencer #(
        .SIZE(SIZE),
        .TAPS(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and land 1 ns after it, so inputs change and
    // outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic writeCoef(input logic [1:0] addr, input logic [SIZE-1:0] val);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = addr;
        bus.coef_wdata = val;
        tick();
        bus.coef_we    = 1'b0;
    endtask

    task automatic writeAll(input logic [SIZE-1:0] c0, input logic [SIZE-1:0] c1,
                            input logic [SIZE-1:0] c2, input logic [SIZE-1:0] c3);
        writeCoef(2'd0, c0);
        writeCoef(2'd1, c1);
        writeCoef(2'd2, c2);
        writeCoef(2'd3, c3);
    endtask

    // Presents one sample for exactly the accept edge.
    task automatic applyStimulus(input logic [SIZE-1:0] data);
        bus.data_in  = data;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, counting edges already spent since the
    // accept edge; returns the total edge count, or 99 on timeout.
    task automatic waitOutValid(input int already, output int edges);
        edges = already;
        while (bus.out_valid !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        if (bus.out_valid !== 1'b1) edges = 99;
    endtask

    // Releases the result with out_ready for one edge and checks the return
    // to IDLE.
    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Full single-sample transaction with latency and result checks.
    task automatic runSample(input string tag, input logic [SIZE-1:0] data,
                             input int expected);
        int edges;
        applyStimulus(data);
        checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        waitOutValid(0, edges);
        checkOutput({tag, "_latency"}, edges, 32'd4);
        checkOutput({tag, "_sop"}, {22'd0, bus.sop_out}, expected);
        consume(tag);
    endtask

    initial begin
        int edges;
        errors         = 0;
        checks         = 0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = 2'd0;
        bus.coef_wdata = '0;
        bus.in_valid   = 1'b0;
        bus.data_in    = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        #22;
        checkOutput("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("rst_sop",       {22'd0, bus.sop_out},   32'd0);
        checkOutput("rst_coef_err",  {31'd0, bus.coef_err},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic sums
        writeAll(4'd1, 4'd1, 4'd1, 4'd1);
        runSample("ones", 4'd1, 4);
        writeAll(4'd5, 4'd5, 4'd5, 4'd5);
        runSample("fives", 4'd5, 100);

        // Distinct taps
        writeAll(4'd1, 4'd2, 4'd3, 4'd4);
        runSample("taps1234", 4'd4, 40);
        writeAll(4'd5, 4'd6, 4'd7, 4'd8);
        runSample("taps5678", 4'd8, 208);

        // Maximum value
        writeAll(4'd15, 4'd15, 4'd15, 4'd15);
        runSample("max", 4'd15, 900);

        // Backpressure: 3*60 = 180, held while a new sample is offered
        applyStimulus(4'd3);
        waitOutValid(0, edges);
        checkOutput("bp_latency", edges, 32'd4);
        bus.data_in  = 4'd7;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_valid_hold", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("bp_sop_hold",   {22'd0, bus.sop_out},   32'd180);
            checkOutput("bp_in_ready",   {31'd0, bus.in_ready},  32'd0);
        end
        // Consume with in_valid still high: must land in IDLE, not MAC
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("bp_idle_busy",  {31'd0, bus.busy},      32'd0);
        checkOutput("bp_idle_ready", {31'd0, bus.in_ready},  32'd1);
        checkOutput("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // Write coinciding with accept: C0 becomes 6 for this sample -> 1*(6+2+3+4)
        writeAll(4'd1, 4'd2, 4'd3, 4'd4);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 2'd0;
        bus.coef_wdata = 4'd6;
        applyStimulus(4'd1);
        bus.coef_we    = 1'b0;
        waitOutValid(0, edges);
        checkOutput("wr_accept_sop", {22'd0, bus.sop_out}, 32'd15);
        consume("wr_accept");

        // Busy write of C2=9 rejected; result uses C2=3 -> 2*(1+2+3+4) = 20
        writeCoef(2'd0, 4'd1);
        applyStimulus(4'd2);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 2'd2;
        bus.coef_wdata = 4'd9;
        tick();
        bus.coef_we    = 1'b0;
        checkOutput("busy_err_pulse", {31'd0, bus.coef_err}, 32'd1);
        tick();
        checkOutput("busy_err_clear", {31'd0, bus.coef_err}, 32'd0);
        waitOutValid(2, edges);
        checkOutput("busy_latency", edges, 32'd4);
        checkOutput("busy_sop", {22'd0, bus.sop_out}, 32'd20);
        consume("busy");
        runSample("readback", 4'd1, 10);

        // Async reset in the 2nd MAC cycle
        applyStimulus(4'd5);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy",  {31'd0, bus.busy},      32'd0);
        checkOutput("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("arst_sop",   {22'd0, bus.sop_out},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        runSample("arst_zero_coef", 4'd9, 0);

        // Async reset while holding a result drops out_valid at once
        writeCoef(2'd0, 4'd1);
        applyStimulus(4'd3);
        waitOutValid(0, edges);
        checkOutput("done_sop", {22'd0, bus.sop_out}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("done_arst_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
